// File: rtl/bcd_calc_ctrl.sv
// Keypad sequencer for a 2-digit packed-BCD calculator: collects digits into an
// entry register, tracks the pending operator and feeds the external BCD add/sub stage.
module bcd_calc_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_sub,
    input  logic [7:0] add_o,
    output logic [7:0] disp,
    output logic [1:0] pend
);

    localparam int W = 4 * DIGITS;
    localparam logic [1:0] MAX_CNT = 2'(DIGITS);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    // Handshake: a key is consumed on a rising edge where key_valid && key_ready.
    // key_ready is high only in IDLE; the source must hold a key across EXEC.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t       state_q, state_n;
    logic [W-1:0] acc_q, acc_n;
    logic [W-1:0] entry_q, entry_n;
    logic [1:0]   cnt_q, cnt_n;
    logic [1:0]   pend_n;
    logic [1:0]   next_pend_q, next_pend_n;
    logic [W-1:0] add_a_n, add_b_n;
    logic         add_sub_n;
    logic [W-1:0] disp_n;
    logic [1:0]   key_op;

    assign key_op = (key_code == KEY_PLUS) ? OP_ADD : OP_SUB;

    always_comb begin
        state_n     = state_q;
        acc_n       = acc_q;
        entry_n     = entry_q;
        cnt_n       = cnt_q;
        pend_n      = pend;
        next_pend_n = next_pend_q;
        add_a_n     = add_a;
        add_b_n     = add_b;
        add_sub_n   = add_sub;

        if (state_q == EXEC) begin
            acc_n   = add_o;
            pend_n  = next_pend_q;
            entry_n = '0;
            cnt_n   = 2'd0;
            state_n = IDLE;
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                // Entry saturates: extra digits are accepted but dropped.
                if (cnt_q < MAX_CNT) begin
                    entry_n = {entry_q[W-5:0], key_code};
                    cnt_n   = cnt_q + 2'd1;
                end
            end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                if (pend == OP_NONE) begin
                    if (cnt_q != 2'd0) acc_n = entry_q;
                    pend_n  = key_op;
                    entry_n = '0;
                    cnt_n   = 2'd0;
                end else if (cnt_q == 2'd0) begin
                    pend_n = key_op;
                end else begin
                    add_a_n     = acc_q;
                    add_b_n     = entry_q;
                    add_sub_n   = (pend == OP_SUB);
                    next_pend_n = key_op;
                    entry_n     = '0;
                    cnt_n       = 2'd0;
                    state_n     = EXEC;
                end
            end else if (key_code == KEY_EQ) begin
                if (pend != OP_NONE && cnt_q != 2'd0) begin
                    add_a_n     = acc_q;
                    add_b_n     = entry_q;
                    add_sub_n   = (pend == OP_SUB);
                    next_pend_n = OP_NONE;
                    state_n     = EXEC;
                end else if (pend != OP_NONE) begin
                    pend_n = OP_NONE;
                end else if (cnt_q != 2'd0) begin
                    acc_n = entry_q;
                end
                entry_n = '0;
                cnt_n   = 2'd0;
            end else if (key_code == KEY_CLR) begin
                acc_n       = '0;
                entry_n     = '0;
                cnt_n       = 2'd0;
                pend_n      = OP_NONE;
                next_pend_n = OP_NONE;
                add_a_n     = '0;
                add_b_n     = '0;
                add_sub_n   = 1'b0;
            end
        end

        // Display follows the entry while digits are being typed, else the accumulator.
        disp_n = (cnt_n != 2'd0) ? entry_n : acc_n;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            entry_q     <= '0;
            cnt_q       <= 2'd0;
            pend        <= OP_NONE;
            next_pend_q <= OP_NONE;
            add_a       <= '0;
            add_b       <= '0;
            add_sub     <= 1'b0;
            disp        <= '0;
            key_ready   <= 1'b1;
        end else begin
            state_q     <= state_n;
            acc_q       <= acc_n;
            entry_q     <= entry_n;
            cnt_q       <= cnt_n;
            pend        <= pend_n;
            next_pend_q <= next_pend_n;
            add_a       <= add_a_n;
            add_b       <= add_b_n;
            add_sub     <= add_sub_n;
            disp        <= disp_n;
            key_ready   <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// Directed bench for bcd_calc_ctrl with a behavioural BCD add/sub stage on add_o.
module tb_bcd_calc_ctrl;

    logic       clk;
    logic       nrst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_sub;
    logic [7:0] add_o;
    logic [7:0] disp;
    logic [1:0] pend;

    int checks = 0;
    int failures = 0;

    bcd_calc_ctrl dut (
        .clk       (clk),
        .nrst      (nrst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sub   (add_sub),
        .add_o     (add_o),
        .disp      (disp),
        .pend      (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream stage: decimal add or 10's-complement subtract, mod 100.
    function automatic logic [7:0] bcd_stage(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int av, bv, r;
        av = int'(a[7:4]) * 10 + int'(a[3:0]);
        bv = int'(b[7:4]) * 10 + int'(b[3:0]);
        r  = sub ? (av - bv + 100) % 100 : (av + bv) % 100;
        return {4'(r / 10), 4'(r % 10)};
    endfunction

    assign add_o = bcd_stage(add_a, add_b, add_sub);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!key_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) begin
            checks++;
            failures++;
            $display("FAIL press_timeout observed=key_ready_low expected=key_ready_high");
        end
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    initial begin
        nrst      = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        tick();
        tick();
        check("rst_disp", disp, 8'h00);
        check("rst_pend", 8'(pend), 8'h00);
        check("rst_ready", 8'(key_ready), 8'h01);
        check("rst_add_a", add_a, 8'h00);
        check("rst_add_b", add_b, 8'h00);
        check("rst_add_sub", 8'(add_sub), 8'h00);
        nrst = 1'b1;

        // 12 + 34 = 46
        press(4'd1); press(4'd2); press(4'd10); press(4'd3); press(4'd4);
        press(4'd12);
        check("t1_add_a", add_a, 8'h12);
        check("t1_add_b", add_b, 8'h34);
        check("t1_add_sub", 8'(add_sub), 8'h00);
        check("t1_ready_exec", 8'(key_ready), 8'h00);
        tick();
        check("t1_disp", disp, 8'h46);
        check("t1_pend", 8'(pend), 8'h00);

        // 05 - 17 = 88 (mod 100), then digit saturation
        press(4'd0); press(4'd5); press(4'd11); press(4'd1); press(4'd7);
        press(4'd12);
        check("t2_add_sub", 8'(add_sub), 8'h01);
        tick();
        check("t2_disp", disp, 8'h88);
        press(4'd1); press(4'd2); press(4'd3);
        check("t2_sat_disp", disp, 8'h12);

        // operator replace: 7 + - 2 = 05
        press(4'd13);
        press(4'd7); press(4'd10); press(4'd11);
        check("t3_replace_pend", 8'(pend), 8'h02);
        check("t3_no_exec", 8'(key_ready), 8'h01);
        check("t3_acc_disp", disp, 8'h07);
        press(4'd2); press(4'd12);
        tick();
        check("t3_disp", disp, 8'h05);

        // chaining: 99 + 01 + -> 00, pend add; then 5 = -> 05
        press(4'd13);
        press(4'd9); press(4'd9); press(4'd10); press(4'd0); press(4'd1);
        press(4'd10);
        check("t4_add_a", add_a, 8'h99);
        check("t4_add_b", add_b, 8'h01);
        tick();
        check("t4_disp", disp, 8'h00);
        check("t4_pend", 8'(pend), 8'h01);
        press(4'd5); press(4'd12);
        tick();
        check("t4_final", disp, 8'h05);

        // '=' held through EXEC is consumed once; second take is a no-op
        press(4'd13);
        press(4'd2); press(4'd10); press(4'd3);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd12;
        tick();
        check("t5_ready_exec", 8'(key_ready), 8'h00);
        check("t5_add_a", add_a, 8'h02);
        tick();
        check("t5_disp", disp, 8'h05);
        tick();
        key_valid = 1'b0;
        check("t5_disp_hold", disp, 8'h05);
        check("t5_pend", 8'(pend), 8'h00);
        check("t5_ready", 8'(key_ready), 8'h01);

        // clear key after 4 2 + 3 gives the all-zero state
        press(4'd4); press(4'd2); press(4'd10); press(4'd3);
        check("t6_entry_disp", disp, 8'h03);
        press(4'd13);
        check("t6_disp", disp, 8'h00);
        check("t6_pend", 8'(pend), 8'h00);
        check("t6_ready", 8'(key_ready), 8'h01);
        check("t6_add_a", add_a, 8'h00);

        // reset asserted during EXEC discards the capture
        press(4'd4); press(4'd2); press(4'd10); press(4'd3); press(4'd12);
        check("t7_in_exec", 8'(key_ready), 8'h00);
        nrst = 1'b0;
        tick();
        check("t7_disp", disp, 8'h00);
        check("t7_pend", 8'(pend), 8'h00);
        check("t7_ready", 8'(key_ready), 8'h01);
        check("t7_add_a", add_a, 8'h00);
        nrst = 1'b1;
        tick();
        check("t7_disp_after", disp, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_calc_ctrl.md
Name: bcd_calc_ctrl

Overview:
- Keypad-driven sequencer for a 2-digit packed-BCD calculator.
- Shifts digit keystrokes into an entry register and holds an accumulator.
- On operator keys, drives operands and the add/sub select into the existing combinational 8-bit BCD add/sub stage, then captures its result into the accumulator one cycle later.
- Sits directly upstream of that stage (feeds a, b, sub) and consumes its result (o).

Parameters:
- DIGITS, 2, BCD digits per operand; fixed at 2, since the datapath is 4*DIGITS bits wide and matches the downstream stage.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  synchronous active-low reset
- key_valid  in  1  key code present
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '=', 13 'C', 14-15 no-op
- key_ready  out  1  high when a key can be accepted
- add_a  out  8  BCD operand A to the add/sub stage (accumulator)
- add_b  out  8  BCD operand B to the add/sub stage (entry)
- add_sub  out  1  1 = subtract (A-B, 10's complement, mod 100)
- add_o  in  8  BCD result from the add/sub stage, valid the same cycle
- disp  out  8  packed BCD value to display
- pend  out  2  pending op: 00 none, 01 add, 10 sub

Behaviour:
- Reset is synchronous: on a clk edge with nrst=0, all registers clear.
  - acc=00, entry=00, cnt=0, pend=00, state=IDLE.
  - add_a=00, add_b=00, add_sub=0, disp=00, key_ready=1.
- Key accept: a key is accepted in a cycle when key_valid && key_ready. key_ready = (state==IDLE).
- States: IDLE, EXEC. EXEC always lasts exactly one cycle and then returns to IDLE.
- IDLE, digit d:
  - If cnt<2: entry <= {entry[3:0], d}, cnt++.
  - If cnt==2: the key is accepted and ignored; entry saturates at 2 digits.
- IDLE, '+' or '-' (new op N):
  - pend==00: if cnt>0, acc <= entry. pend <= N; entry <= 00; cnt <= 0.
  - pend!=00 and cnt==0: pend <= N only (operator replace, no execution).
  - pend!=00 and cnt>0: register add_a=acc, add_b=entry, add_sub=(pend==10); go to EXEC; latch N as the next pend.
- IDLE, '=':
  - pend!=00 and cnt>0: execute as above; next pend = 00.
  - pend!=00 and cnt==0: pend <= 00, acc unchanged.
  - pend==00 and cnt>0: acc <= entry.
  - In every case entry <= 00 and cnt <= 0.
- EXEC: at the end of the cycle, acc <= add_o, pend <= latched next op, entry <= 00, cnt <= 0.
- Latency: result visible in acc/disp 2 cycles after the operator key is accepted.
- key_ready is low during EXEC; key_valid in EXEC is not consumed, so the source must hold it.
- add_a, add_b and add_sub are registered and hold their last value outside EXEC.
- IDLE, 'C': same effect as reset, in one cycle.
- IDLE, codes 14-15: accepted, no state change.
- disp is registered: entry when cnt>0, else acc. It updates on the edge that changes the selected value.
- Arithmetic is owned by the downstream stage. This block never modifies add_o; results wrap mod 100, with no overflow flag.
- Reset during EXEC: reset wins and the capture is discarded.

Test Plan:
- Keys 1,2,'+',3,4,'=' -> disp 0x46 two cycles after '=' accepted; add_a=0x12, add_b=0x34, add_sub=0 during EXEC; pend=00.
- Keys 0,5,'-',1,7,'=' -> add_sub=1 in EXEC; acc/disp 0x88; keys 1,2,3 -> entry/disp 0x12, third digit ignored.
- Keys 7,'+','-',2,'=' -> '-' replaces '+' with no EXEC cycle; result disp 0x05.
- Chaining 9,9,'+',0,1,'+' -> EXEC on second '+', acc 0x00, pend=01; then 5,'=' -> 0x05.
- Hold key_valid=1 with '=' through EXEC -> consumed once only (key_ready=0 in EXEC); next cycle's '=' is a no-op (pend=00, cnt=0).
- nrst=0 during EXEC -> next cycle acc=00, disp=00, pend=00, key_ready=1; 'C' after 4,2,'+',3 -> same all-zero state.
